mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: the wait-cycle limit per memory phase before abort.
REQ-002 SHALL have parameter DATA_W, default 16: the width of the LC-3 address and data words.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1 bit: an access request is present.
REQ-006 SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-007 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_ind, input, 1 bit: 1 = indirect (LDI/STI) access through a pointer.
REQ-009 SHALL have port req_addr, input, 16 bits: the effective address (EAB sum).
REQ-010 SHALL have port req_wdata, input, 16 bits: the store data.
REQ-011 SHALL have port rsp_valid, output, 1 bit: a one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata, output, 16 bits: the MDR contents at completion.
REQ-013 SHALL have port rsp_err, output, 1 bit: the access was aborted by timeout; valid only with rsp_valid.
REQ-014 SHALL have port mem_en, output, 1 bit: a memory cycle is in progress.
REQ-015 SHALL have port mem_we, output, 1 bit: the memory cycle is a write.
REQ-016 SHALL have port mem_addr, output, 16 bits: equals MAR.
REQ-017 SHALL have port mem_wdata, output, 16 bits: equals MDR.
REQ-018 SHALL have port mem_rdata, input, 16 bits: the read data, valid when mem_ready=1.
REQ-019 SHALL have port mem_ready, input, 1 bit: the memory completes the current cycle.

Function
REQ-020 SHALL implement states IDLE, IND_RD, RD, WR and DONE, all registered.
REQ-021 SHALL drive req_ready=1 only in IDLE; a request is accepted on the clk edge where req_valid and req_ready are both 1.
REQ-022 SHALL, on accept, load MAR from req_addr and MDR from req_wdata.
REQ-023 SHALL, on accept, go to IND_RD if req_ind=1, otherwise to WR if req_we=1, otherwise to RD.
REQ-024 SHALL latch req_we and req_ind at accept, so later changes on the request inputs have no effect.
REQ-025 SHALL drive mem_en=1 in IND_RD, RD and WR, and mem_en=0 otherwise.
REQ-026 SHALL drive mem_we=1 only in WR.
REQ-027 SHALL hold mem_addr and mem_wdata stable while mem_en=1 and mem_ready=0.
REQ-028 SHALL, in IND_RD with mem_ready=1, load MAR from mem_rdata and go to WR if the latched we=1, otherwise to RD.
REQ-029 SHALL, in RD with mem_ready=1, load MDR from mem_rdata and go to DONE.
REQ-030 SHALL, in WR with mem_ready=1, go to DONE with MDR unchanged.
REQ-031 SHALL ignore mem_ready whenever mem_en=0.
REQ-032 SHALL, in DONE, assert rsp_valid=1 for exactly one cycle with rsp_rdata=MDR, then go to IDLE; the response has no backpressure.
REQ-033 SHALL give these latencies with mem_ready=1 on the first cycle: accept at edge N, direct access rsp_valid in cycle N+2, indirect access rsp_valid in cycle N+3.
REQ-034 SHALL clear the wait counter on every phase entry and increment it each cycle with mem_en=1 and mem_ready=0.
REQ-035 SHALL, when the wait counter reaches TIMEOUT_CYCLES with mem_ready still 0, abort to DONE with rsp_err=1 and MDR unchanged.
REQ-036 SHALL give mem_ready=1 priority over timeout in the cycle where the counter would reach the limit.
REQ-037 SHALL treat all 16-bit addresses including x0000 and xFFFF identically, with no address arithmetic or wrap logic.
REQ-038 SHALL never accept a new request while DONE is active; acceptance is possible no earlier than the cycle after rsp_valid.

Reset
REQ-039 SHALL, while rst_n=0, force the state to IDLE and set MAR=0, MDR=0, wait counter=0 and the latched we/ind=0.
REQ-040 SHALL, while rst_n=0, drive mem_en=0, mem_we=0, rsp_valid=0, rsp_err=0 and req_ready=0.
REQ-041 SHALL, on reset asserted mid-access, drop mem_en asynchronously and produce no rsp_valid for the aborted access.
REQ-042 SHALL raise req_ready on the first clk edge after rst_n deasserts.

Structure
REQ-043 SHALL place the state enum, the DATA_W constant and the TIMEOUT_CYCLES default in shared package lc3_mem_pkg.
REQ-044 SHALL implement the wait counter as sub-module mem_ctrl_timer (inputs clear and count; output expired); everything else stays in mem_ctrl.

Verification
REQ-045 SHALL test direct load: req_addr=x3000, memory returns x1234 with zero wait -> mem_en/addr x3000 in cycle N+1, rsp_valid N+2, rdata x1234, err 0.
REQ-046 SHALL test direct store: addr=x4001, wdata=xBEEF, mem_ready after 3 wait cycles -> mem_we=1, wdata xBEEF held 4 cycles, then rsp_valid, rdata xBEEF.
REQ-047 SHALL test LDI: addr=x3010, memory[x3010]=x5000, memory[x5000]=x00AA -> two mem_en phases at addresses x3010 then x5000, rsp_rdata x00AA at N+3.
REQ-048 SHALL test timeout: TIMEOUT_CYCLES=4, mem_ready held 0 -> rsp_valid with rsp_err=1 after 4 wait cycles, MDR unchanged, and mem_ready=1 on the limit cycle gives no error.
REQ-049 SHALL test reset mid-IND_RD: mem_en drops immediately, no rsp_valid, req_ready=1 after release, and a following direct load completes normally.
REQ-050 SHALL test back-to-back: req_valid held high across two requests -> second accepted only in the cycle after the first rsp_valid; mem_ready pulses while idle cause no state change.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory access controller.
package lc3_mem_pkg;

  localparam int LC3_DATA_W         = 16;
  localparam int LC3_TIMEOUT_CYCLES = 255;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IND_RD = 3'd1,
    ST_RD     = 3'd2,
    ST_WR     = 3'd3,
    ST_DONE   = 3'd4
  } mem_state_e;

  function automatic logic is_mem_phase(input mem_state_e s);
    return (s == ST_IND_RD) || (s == ST_RD) || (s == ST_WR);
  endfunction

endpackage

// File: rtl/mem_ctrl_timer.sv
// Per-phase wait counter; expired fires on the wait cycle that would reach LIMIT.
module mem_ctrl_timer
  import lc3_mem_pkg::*;
#(
  parameter int LIMIT = LC3_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // The counter never needs to hold LIMIT itself: the phase ends on that cycle.
  assign expired = count && (cnt_q == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// LC-3 MAR/MDR memory access sequencer: direct and indirect loads/stores with per-phase timeout.
//   state   | meaning
//   IDLE    | req_ready=1, waiting for a request
//   IND_RD  | reading the pointer at MAR; result becomes the new MAR
//   RD      | reading memory at MAR into MDR
//   WR      | writing MDR to memory at MAR
//   DONE    | one-cycle response pulse, then back to IDLE
module mem_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = LC3_TIMEOUT_CYCLES,
  parameter int DATA_W         = LC3_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_ind,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  mem_state_e        state_q, state_d;
  logic [DATA_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              we_q, we_d;
  logic              ind_q, ind_d;
  logic              req_ready_q, req_ready_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic              abort;
  logic              tmr_clear;
  logic              tmr_count;
  logic              tmr_expired;

  assign tmr_count = mem_en_q && !mem_ready;
  assign tmr_clear = (state_d != state_q);

  mem_ctrl_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmr_clear),
    .count   (tmr_count),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    we_d    = we_q;
    ind_d   = ind_q;
    abort   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          mar_d   = req_addr;
          mdr_d   = req_wdata;
          we_d    = req_we;
          ind_d   = req_ind;
          state_d = req_ind ? ST_IND_RD : (req_we ? ST_WR : ST_RD);
        end
      end
      ST_IND_RD: begin
        if (mem_ready) begin
          mar_d   = mem_rdata;
          ind_d   = 1'b0;
          state_d = we_q ? ST_WR : ST_RD;
        end else if (tmr_expired) begin
          abort   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_RD: begin
        if (mem_ready) begin
          mdr_d   = mem_rdata;
          state_d = ST_DONE;
        end else if (tmr_expired) begin
          abort   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_WR: begin
        if (mem_ready) begin
          state_d = ST_DONE;
        end else if (tmr_expired) begin
          abort   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they leave the flops aligned with it.
    req_ready_d = (state_d == ST_IDLE);
    mem_en_d    = is_mem_phase(state_d);
    mem_we_d    = (state_d == ST_WR);
    rsp_valid_d = (state_d == ST_DONE);
    rsp_err_d   = abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mar_q       <= '0;
      mdr_q       <= '0;
      we_q        <= 1'b0;
      ind_q       <= 1'b0;
      req_ready_q <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mar_q       <= mar_d;
      mdr_q       <= mdr_d;
      we_q        <= we_d;
      ind_q       <= ind_d;
      req_ready_q <= req_ready_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = mdr_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: transaction-timeline model, memory responder, directed and random accesses.
module tb_mem_ctrl;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_ind;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  mem_ctrl #(
    .TIMEOUT_CYCLES (TO),
    .DATA_W         (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_ind   (req_ind),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int ntests = 0;
  int nfail  = 0;

  logic [15:0] mem [0:65535];
  int          w_cfg [2];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endfunction

  // Memory: answers each phase after the configured number of wait cycles; random
  // ready/data outside of phases and while waiting.
  initial begin : responder
    int left;
    bit prev_en;
    bit prev_rdy;
    left = 0; prev_en = 0; prev_rdy = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_en) begin
        if (!prev_en) left = w_cfg[0];
        else if (prev_rdy) left = w_cfg[1];
        if (left == 0) begin
          mem_ready = 1'b1;
          mem_rdata = mem[mem_addr];
        end else begin
          left--;
          mem_ready = 1'b0;
          mem_rdata = 16'($urandom);
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = 16'($urandom);
      end
      prev_en  = mem_en;
      prev_rdy = mem_en && mem_ready;
    end
  end

  // Reference model: each accepted request becomes a list of expected cycles.
  typedef struct packed {
    bit          en;
    bit          we;
    bit          rv;
    bit          err;
    bit          rdy;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  exp_t        tl[$];
  int          tl_idx = 0;
  bit          m_busy = 0;
  bit          m_rdy  = 0;
  logic [15:0] m_mar  = '0;
  logic [15:0] m_mdr  = '0;

  function automatic void add_phase(input logic [15:0] a, input bit we, input logic [15:0] d, input int w);
    exp_t e;
    int   n;
    n = (w >= TO) ? TO : w + 1;
    for (int i = 0; i < n; i++) begin
      e = '0;
      e.en = 1; e.we = we; e.addr = a; e.wdata = d;
      tl.push_back(e);
    end
  endfunction

  function automatic void build(input bit we, input bit ind, input logic [15:0] addr,
                                input logic [15:0] wdata, input int w0, input int w1);
    exp_t        e;
    bit          ab;
    int          wl;
    logic [15:0] a;
    logic [15:0] rd;
    ab = 0; a = addr; rd = wdata;
    tl.delete();
    if (ind) begin
      add_phase(addr, 1'b0, wdata, w0);
      if (w0 >= TO) ab = 1;
      else a = mem[addr];
    end
    if (!ab) begin
      wl = ind ? w1 : w0;
      add_phase(a, we, wdata, wl);
      if (wl >= TO) ab = 1;
      else if (!we) rd = mem[a];
    end
    e = '0;
    e.rv = 1; e.err = ab; e.addr = a; e.wdata = rd; e.rdata = rd;
    tl.push_back(e);
    m_mar = a;
    m_mdr = rd;
  endfunction

  function automatic void model_reset();
    m_busy = 0; m_rdy = 0; m_mar = '0; m_mdr = '0; tl_idx = 0;
  endfunction

  initial begin : compare
    exp_t e;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        model_reset();
      end else if (m_busy) begin
        tl_idx++;
        if (tl_idx >= tl.size()) begin
          m_busy = 0;
          m_rdy  = 1;
        end
      end else if (m_rdy && req_valid) begin
        build(req_we, req_ind, req_addr, req_wdata, w_cfg[0], w_cfg[1]);
        m_busy = 1; m_rdy = 0; tl_idx = 0;
      end else begin
        m_rdy = 1;
      end
      @(negedge clk);
      if (!rst_n) begin
        model_reset();
        e = '0;
      end else if (m_busy) begin
        e = tl[tl_idx];
      end else begin
        e = '0;
        e.rdy = m_rdy; e.addr = m_mar; e.wdata = m_mdr;
      end
      chk("req_ready", 32'(req_ready), 32'(e.rdy));
      chk("mem_en", 32'(mem_en), 32'(e.en));
      chk("mem_we", 32'(mem_we), 32'(e.we));
      chk("rsp_valid", 32'(rsp_valid), 32'(e.rv));
      chk("mem_addr", 32'(mem_addr), 32'(e.addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
      if (e.rv || !rst_n) chk("rsp_err", 32'(rsp_err), 32'(e.err));
      if (e.rv) chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called one step into a cycle where the DUT is ready; returns one step into N+1.
  task automatic issue(input bit we, input bit ind, input logic [15:0] addr,
                       input logic [15:0] wdata, input int w0, input int w1);
    w_cfg[0] = w0; w_cfg[1] = w1;
    req_we = we; req_ind = ind; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    req_we    = 1'($urandom_range(0, 1));
    req_ind   = 1'($urandom_range(0, 1));
    req_addr  = 16'($urandom);
    req_wdata = 16'($urandom);
  endtask

  task automatic wait_rsp(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!rsp_valid && cycles < 40);
    if (!rsp_valid) chk("rsp_wait", 32'(rsp_valid), 32'd1);
  endtask

  initial begin : main
    int          c;
    int          first;
    int          second;
    int          pulses;
    logic [15:0] a;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_ind = 1'b0;
    req_addr = '0; req_wdata = '0; w_cfg[0] = 0; w_cfg[1] = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mar", 32'(mem_addr), 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready_low", 32'(req_ready), 32'd0);
    step();
    chk("rel_ready_high", 32'(req_ready), 32'd1);

    // direct load, zero wait
    mem[16'h3000] = 16'h1234;
    issue(1'b0, 1'b0, 16'h3000, 16'h0000, 0, 0);
    @(negedge clk);
    chk("ld_en", 32'(mem_en), 32'd1);
    chk("ld_addr", 32'(mem_addr), 32'h3000);
    @(negedge clk);
    chk("ld_rv", 32'(rsp_valid), 32'd1);
    chk("ld_rdata", 32'(rsp_rdata), 32'h1234);
    chk("ld_err", 32'(rsp_err), 32'd0);
    step();

    // direct store, 3 wait cycles
    issue(1'b1, 1'b0, 16'h4001, 16'hBEEF, 3, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("st_we", 32'(mem_we), 32'd1);
      chk("st_wdata", 32'(mem_wdata), 32'hBEEF);
    end
    @(negedge clk);
    chk("st_rv", 32'(rsp_valid), 32'd1);
    chk("st_rdata", 32'(rsp_rdata), 32'hBEEF);
    step();

    // LDI
    mem[16'h3010] = 16'h5000;
    mem[16'h5000] = 16'h00AA;
    issue(1'b0, 1'b1, 16'h3010, 16'h0000, 0, 0);
    @(negedge clk);
    chk("ldi_ptr_addr", 32'(mem_addr), 32'h3010);
    @(negedge clk);
    chk("ldi_data_addr", 32'(mem_addr), 32'h5000);
    @(negedge clk);
    chk("ldi_rv", 32'(rsp_valid), 32'd1);
    chk("ldi_rdata", 32'(rsp_rdata), 32'h00AA);
    step();

    // timeout, then ready on the limit cycle
    issue(1'b0, 1'b0, 16'h2000, 16'h5A5A, 9, 0);
    wait_rsp(c);
    chk("to_lat", 32'(c), 32'd5);
    chk("to_err", 32'(rsp_err), 32'd1);
    chk("to_rdata", 32'(rsp_rdata), 32'h5A5A);
    step();
    mem[16'h2000] = 16'h7E7E;
    issue(1'b0, 1'b0, 16'h2000, 16'h1111, TO - 1, 0);
    wait_rsp(c);
    chk("lim_lat", 32'(c), 32'd5);
    chk("lim_err", 32'(rsp_err), 32'd0);
    chk("lim_rdata", 32'(rsp_rdata), 32'h7E7E);
    step();

    // reset during IND_RD
    issue(1'b0, 1'b1, 16'h3010, 16'h0BAD, 3, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_en", 32'(mem_en), 32'd0);
    pulses = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready_low", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("midrst_ready_high", 32'(req_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    chk("midrst_no_rsp", 32'(pulses), 32'd0);
    step();
    issue(1'b0, 1'b0, 16'h3000, 16'h0000, 0, 0);
    wait_rsp(c);
    chk("postrst_lat", 32'(c), 32'd2);
    chk("postrst_rdata", 32'(rsp_rdata), 32'h1234);
    step();

    // back-to-back with req_valid held high, boundary addresses
    mem[16'h0000] = 16'hA0A0;
    mem[16'hFFFF] = 16'hB1B1;
    w_cfg[0] = 0; w_cfg[1] = 0;
    req_we = 1'b0; req_ind = 1'b0; req_addr = 16'h0000; req_wdata = 16'h1111; req_valid = 1'b1;
    step();
    req_addr = 16'hFFFF; req_wdata = 16'h2222;
    first = -1; second = -1;
    for (int k = 1; k <= 20 && second < 0; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        if (first < 0) begin
          first = k;
          chk("b2b_rdata0", 32'(rsp_rdata), 32'hA0A0);
        end else begin
          second = k;
          chk("b2b_rdata1", 32'(rsp_rdata), 32'hB1B1);
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    chk("b2b_first", 32'(first), 32'd2);
    chk("b2b_gap", 32'(second - first), 32'd3);
    repeat (4) @(posedge clk);
    step();

    // random traffic
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0:       a = 16'h0000;
        1:       a = 16'hFFFF;
        default: a = 16'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) mem[a] = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0000;
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom),
            int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
      wait_rsp(c);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", nfail);
    $fatal(1);
  end

endmodule
